// File: rtl/eth_tx_fifo_arb.sv
// Frame-granular round-robin arbiter feeding {last, data} words into the TX async FIFO write port.
// Optional per-source frame and truncation counters are enabled with ETH_TX_ARB_STATS_EN.
module eth_tx_fifo_arb #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    input  logic              fifo_wfull,
    input  logic              fifo_awfull,
    output logic              fifo_winc,
    output logic [DATA_W:0]   fifo_wdata,
    output logic [1:0]        grant,
    output logic              trunc
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [15:0]       s0_frames,
    output logic [15:0]       s1_frames,
    output logic [7:0]        trunc_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, G0, G1, D0, D1} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_ptr;
    logic              w_rr_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_sel1;
    logic              w_valid;
    logic              w_last;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic              w_wr;
    logic              w_last_eff;
    logic              w_trunc;

    // Next-state, readiness and write decision for the granted source
    always_comb begin
        w_next     = r_state;
        w_rr_next  = r_rr_ptr;
        w_cnt_next = r_cnt;
        w_ready    = 1'b0;
        w_wr       = 1'b0;
        w_last_eff = 1'b0;
        w_trunc    = 1'b0;
        w_sel1     = (r_state == G1) || (r_state == D1);
        w_valid    = w_sel1 ? s1_valid : s0_valid;
        w_last     = w_sel1 ? s1_last  : s0_last;
        w_data     = w_sel1 ? s1_data  : s0_data;
        case (r_state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    w_next = r_rr_ptr ? G1 : G0;
                end else if (s0_valid) begin
                    w_next = G0;
                end else if (s1_valid) begin
                    w_next = G1;
                end
            end
            G0, G1: begin
                // awfull leaves one spare entry for the write already in flight
                w_ready = !fifo_awfull && !fifo_wfull;
                if (w_valid && w_ready) begin
                    w_wr = 1'b1;
                    if (w_last) begin
                        w_last_eff = 1'b1;
                        w_next     = IDLE;
                        w_rr_next  = !w_sel1;
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_W'(MAX_LEN - 1)) begin
                        w_last_eff = 1'b1;
                        w_trunc    = 1'b1;
                        w_next     = w_sel1 ? D1 : D0;
                        w_rr_next  = !w_sel1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            D0, D1: begin
                w_ready = 1'b1;
                if (w_valid && w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        s0_ready = w_ready && !w_sel1;
        s1_ready = w_ready && w_sel1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_cnt      <= '0;
            fifo_winc  <= 1'b0;
            fifo_wdata <= '0;
            grant      <= 2'b00;
            trunc      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rr_ptr   <= w_rr_next;
            r_cnt      <= w_cnt_next;
            fifo_winc  <= w_wr;
            fifo_wdata <= {w_last_eff, w_data};
            grant      <= {(w_next == G1) || (w_next == D1), (w_next == G0) || (w_next == D0)};
            trunc      <= w_trunc;
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    // Frame counters advance together with the write of each frame's final word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_frames <= 16'd0;
            s1_frames <= 16'd0;
            trunc_cnt <= 8'd0;
        end else begin
            if (w_wr && w_last_eff && !w_sel1 && (s0_frames != 16'hFFFF)) begin
                s0_frames <= s0_frames + 16'd1;
            end
            if (w_wr && w_last_eff && w_sel1 && (s1_frames != 16'hFFFF)) begin
                s1_frames <= s1_frames + 16'd1;
            end
            if (w_trunc && (trunc_cnt != 8'hFF)) begin
                trunc_cnt <= trunc_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
